// File: rtl/net_rx_link_ctrl_if.sv
// ---------------------------------------------------------------------------
// net_rx_link_ctrl_if
//
// Bundles the signals between the link controller, its receiver and the host
// register block.
//
//   link_enable      host request to run the link
//   rx_valid         receiver word strobe
//   rx_end           receiver end-of-packet flag (qualified by rx_valid)
//   rx_enable        receiver enable
//   rx_phase_shift   receiver phase-shift select, $clog2(PHASES) bits
//   link_up          link locked
//   frame_count      frame ends received while locked (16 bits, wraps)
//   retrain_count    lock losses (8 bits, saturates)
//   state            0=IDLE 1=SETTLE 2=HUNT 3=LOCKED
//
// The master modport is the controller's view. The slave modport is the view
// from the receiver and host side.
// ---------------------------------------------------------------------------
interface net_rx_link_ctrl_if #(
    parameter int PHASES = 4
);
    localparam int PW = $clog2(PHASES);

    logic          link_enable;
    logic          rx_valid;
    logic          rx_end;
    logic          rx_enable;
    logic [PW-1:0] rx_phase_shift;
    logic          link_up;
    logic [15:0]   frame_count;
    logic [7:0]    retrain_count;
    logic [1:0]    state;

    modport master (
        input  link_enable, rx_valid, rx_end,
        output rx_enable, rx_phase_shift, link_up, frame_count, retrain_count, state
    );

    modport slave (
        output link_enable, rx_valid, rx_end,
        input  rx_enable, rx_phase_shift, link_up, frame_count, retrain_count, state
    );
endinterface

// File: rtl/net_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// net_rx_link_ctrl
//
// Link-training and supervision controller for one multi-phase net receiver.
// After a settle period it hunts over receiver phase-shift values until
// GOOD_FRAMES consecutive frame ends arrive, then declares the link up. While
// locked it counts frames and watches for loss. A loss retrains from the
// phase that was last good.
//
// Ports:
//   clk    receiver sampling clock, phase 0 (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    net_rx_link_ctrl_if.master: link_enable, rx_valid and rx_end are
//          inputs; rx_enable, rx_phase_shift, link_up, frame_count,
//          retrain_count and state are registered outputs
// ---------------------------------------------------------------------------
module net_rx_link_ctrl #(
    parameter int PHASES         = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GOOD_FRAMES    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    net_rx_link_ctrl_if.master        bus
);
    localparam int PW = $clog2(PHASES);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int GW = $clog2(GOOD_FRAMES + 1);

    localparam logic [PW-1:0] PHASE_LAST  = PW'(PHASES - 1);
    localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(GOOD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HUNT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [GW-1:0] good_q, good_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [15:0]   frame_q, frame_d;
    logic [7:0]    retrain_q, retrain_d;
    logic          rx_enable_q, rx_enable_d;
    logic          link_up_q, link_up_d;

    // A frame end is only real when the receiver also strobes a valid word.
    logic fe;
    assign fe = bus.rx_valid & bus.rx_end;

    // Next-state logic. A dropped link_enable sends the FSM to IDLE from
    // anywhere while keeping the phase and the counters. A frame end in the
    // same cycle as the watchdog limit wins, so the link is never declared
    // lost on a cycle that actually delivered a frame. An HUNT timeout moves
    // to the next phase. A LOCKED timeout retries the current phase first,
    // because that phase was the last one that worked.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        wd_d      = wd_q;
        good_d    = good_q;
        phase_d   = phase_q;
        frame_d   = frame_q;
        retrain_d = retrain_q;

        if (!bus.link_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = HUNT;
                        good_d  = '0;
                        wd_d    = '0;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                HUNT: begin
                    if (fe) begin
                        wd_d   = '0;
                        good_d = good_q + 1'b1;
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                        end
                    end else if (wd_q == WD_LAST) begin
                        phase_d  = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
                        good_d   = '0;
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (fe) begin
                        wd_d    = '0;
                        frame_d = frame_q + 16'd1;
                    end else if (wd_q == WD_LAST) begin
                        if (retrain_q != 8'hFF) begin
                            retrain_d = retrain_q + 8'd1;
                        end
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The status outputs follow the next state so that they change on
        // the same edge as the state register.
        rx_enable_d = (state_d == HUNT) || (state_d == LOCKED);
        link_up_d   = (state_d == LOCKED);
    end

    // State and counter registers. The asynchronous reset returns every
    // register to zero at once, even in the middle of a settle period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            wd_q        <= '0;
            good_q      <= '0;
            phase_q     <= '0;
            frame_q     <= '0;
            retrain_q   <= '0;
            rx_enable_q <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            wd_q        <= wd_d;
            good_q      <= good_d;
            phase_q     <= phase_d;
            frame_q     <= frame_d;
            retrain_q   <= retrain_d;
            rx_enable_q <= rx_enable_d;
            link_up_q   <= link_up_d;
        end
    end

    assign bus.rx_enable      = rx_enable_q;
    assign bus.rx_phase_shift = phase_q;
    assign bus.link_up        = link_up_q;
    assign bus.frame_count    = frame_q;
    assign bus.retrain_count  = retrain_q;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_net_rx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_net_rx_link_ctrl
//
// Directed bench for net_rx_link_ctrl with PHASES=4, SETTLE_CYCLES=4,
// TIMEOUT_CYCLES=32 and GOOD_FRAMES=3. The stimulus pushes expected output
// values into a scoreboard. Each value is tagged with the cycle in which it
// must be seen. A monitor compares the outputs against the scoreboard on
// every falling edge.
// ---------------------------------------------------------------------------
module tb_net_rx_link_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;

    net_rx_link_ctrl_if #(.PHASES(4)) bus ();

    net_rx_link_ctrl #(
        .PHASES(4),
        .SETTLE_CYCLES(4),
        .TIMEOUT_CYCLES(32),
        .GOOD_FRAMES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t scb[$];
    int   checks   = 0;
    int   failures = 0;

    // Free-running clock, with a cycle index that advances on each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string selName(int sel);
        case (sel)
            0:       return "state";
            1:       return "rx_enable";
            2:       return "rx_phase_shift";
            3:       return "link_up";
            4:       return "frame_count";
            default: return "retrain_count";
        endcase
    endfunction

    function automatic logic [15:0] sample(int sel);
        case (sel)
            0:       return 16'(bus.state);
            1:       return 16'(bus.rx_enable);
            2:       return 16'(bus.rx_phase_shift);
            3:       return 16'(bus.link_up);
            4:       return bus.frame_count;
            default: return 16'(bus.retrain_count);
        endcase
    endfunction

    function automatic void expectAt(int c, int sel, int v);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = 16'(v);
        scb.push_back(e);
    endfunction

    task automatic checkOutput(exp_t e);
        logic [15:0] act;
        checks++;
        act = sample(e.sel);
        if (e.cyc < cyc) begin
            failures++;
            $display("[TB] FAIL %s@%0d: expectation missed, now cycle %0d", selName(e.sel), e.cyc, cyc);
        end else if (act !== e.val) begin
            failures++;
            $display("[TB] FAIL %s@%0d: got %0d, expected %0d", selName(e.sel), e.cyc, act, e.val);
        end
    endtask

    // Scoreboard monitor. Outputs change only on rising edges, so they are
    // stable when sampled here.
    always @(negedge clk) begin
        for (int i = scb.size() - 1; i >= 0; i--) begin
            if (scb[i].cyc <= cyc) begin
                checkOutput(scb[i]);
                scb.delete(i);
            end
        end
    end

    task automatic applyStimulus(input logic le, input logic v, input logic e);
        bus.link_enable = le;
        bus.rx_valid    = v;
        bus.rx_end      = e;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Frame end seen by the DUT with its state as of cycle 'at'.
    task automatic pulseFe(input int at);
        waitCycle(at);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitCycle(at + 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    int c0, h, lk, h0, b, b1, bi, bl;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Values held during reset.
        waitCycle(1);
        for (int s = 0; s < 6; s++) expectAt(2, s, 0);
        waitCycle(3);
        rst_n = 1'b1;

        // Enable: SETTLE in cycles 1..4, HUNT from cycle 5.
        waitCycle(4);
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectAt(c0 + 1, 0, 1); expectAt(c0 + 1, 1, 0);
        expectAt(c0 + 4, 0, 1); expectAt(c0 + 4, 1, 0);
        expectAt(c0 + 5, 0, 2); expectAt(c0 + 5, 1, 1);
        expectAt(c0 + 5, 2, 0); expectAt(c0 + 5, 3, 0);

        // Lock after 3 frames spaced 10 cycles apart, then count 5 frames.
        // rx_end without rx_valid must be ignored.
        h  = c0 + 5;
        lk = h + 30;
        expectAt(h + 29, 0, 2); expectAt(h + 29, 3, 0);
        expectAt(lk, 0, 3); expectAt(lk, 3, 1); expectAt(lk, 4, 0);
        expectAt(lk + 6, 4, 0);
        expectAt(lk + 49, 4, 4); expectAt(lk + 50, 4, 5);
        pulseFe(h + 9);
        pulseFe(h + 19);
        pulseFe(h + 29);
        waitCycle(lk + 5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCycle(lk + 6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) pulseFe(lk - 1 + 10 * k);

        // A frame arriving in the cycle where the watchdog is at 31 prevents
        // the timeout. Then a real loss occurs with the phase kept.
        expectAt(lk + 81, 0, 3);
        expectAt(lk + 82, 0, 3); expectAt(lk + 82, 3, 1);
        expectAt(lk + 82, 4, 6); expectAt(lk + 82, 2, 0);
        expectAt(lk + 113, 0, 3);
        expectAt(lk + 114, 0, 1); expectAt(lk + 114, 3, 0);
        expectAt(lk + 114, 5, 1); expectAt(lk + 114, 1, 0);
        expectAt(lk + 114, 2, 0);
        pulseFe(lk + 81);

        // Hunting without frames: 32 HUNT cycles and 4 SETTLE cycles for
        // each phase step. The phase wraps from 3 to 0.
        h0 = lk + 118;
        for (int k = 0; k < 6; k++) begin
            b = h0 + 36 * k;
            expectAt(b + 31, 0, 2); expectAt(b + 31, 2, k % 4);
            expectAt(b + 32, 0, 1); expectAt(b + 32, 1, 0);
            expectAt(b + 32, 2, (k + 1) % 4);
            expectAt(b + 35, 1, 0);
            expectAt(b + 36, 0, 2); expectAt(b + 36, 1, 1);
            waitCycle(b + 30);
        end

        // Lock at phase 2, then drop link_enable. The FSM goes to IDLE with no
        // retrain counted and the phase kept.
        b = h0 + 216;
        expectAt(b, 5, 1);
        expectAt(b + 3, 0, 3); expectAt(b + 3, 3, 1); expectAt(b + 3, 4, 6);
        expectAt(b + 11, 0, 0); expectAt(b + 11, 1, 0); expectAt(b + 11, 3, 0);
        expectAt(b + 11, 5, 1); expectAt(b + 11, 2, 2); expectAt(b + 11, 4, 6);
        expectAt(b + 18, 0, 2); expectAt(b + 18, 2, 2);
        waitCycle(b);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitCycle(b + 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycle(b + 10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycle(b + 13);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Repeated losses at phase 2. retrain_count saturates at 255, and the
        // frames that complete each lock are not counted.
        b1 = b + 18;
        for (int i = 0; i < 300; i++) begin
            bi = b1 + 39 * i;
            if (i == 0) begin
                expectAt(bi + 3, 0, 3); expectAt(bi + 3, 4, 6);
                expectAt(bi + 35, 0, 1); expectAt(bi + 35, 3, 0);
                expectAt(bi + 35, 5, 2); expectAt(bi + 35, 2, 2);
            end
            if (i == 252 || i == 253 || i == 299) begin
                expectAt(bi + 35, 5, (i + 2 > 255) ? 255 : i + 2);
            end
            if (i == 299) begin
                expectAt(bi + 35, 2, 2); expectAt(bi + 35, 4, 6);
            end
            waitCycle(bi);
            applyStimulus(1'b1, 1'b1, 1'b1);
            waitCycle(bi + 3);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end

        // Short asynchronous reset pulse during SETTLE, released before the
        // next clock edge. Everything must be back at its reset value.
        bl = b1 + 39 * 299;
        waitCycle(bl + 36);
        for (int s = 0; s < 6; s++) expectAt(bl + 37, s, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        waitCycle(bl + 38);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectAt(bl + 39, 0, 1); expectAt(bl + 39, 1, 0);
        waitCycle(bl + 40);

        // Let the scoreboard drain, within a bounded number of cycles.
        for (int n = 0; n < 50 && scb.size() > 0; n++) @(negedge clk);
        while (scb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s@%0d: never checked, got none, expected %0d",
                     selName(scb[0].sel), scb[0].cyc, scb[0].val);
            void'(scb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
